// File: rtl/risc_pack.sv
// Shared definitions for the qrisc32 data-memory slave and its write buffer.
package risc_pack;

  // Controller states: INIT zero-fills the SRAM, RUN serves the bus.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dmem_state_e;

  // Default geometry: 1024-word SRAM, 4-entry write buffer.
  localparam int AW_DEFAULT       = 10;
  localparam int WB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/qrisc32_wbuf.sv
// Write buffer: FIFO of (address, data) pairs with a parallel lookup that
// reports whether an address is buffered and, if so, the youngest data for it.
module qrisc32_wbuf
  import risc_pack::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [31:0]   head_data,
  output logic          full,
  output logic          empty,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [31:0]   hit_data
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push   = push & (~full | pop);
  assign do_pop    = pop & ~empty;
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // FIFO storage, power-of-two wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan live entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (addr_mem[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/qrisc32_dmem_slave.sv
// Data-memory slave for qrisc32: zero-fills a single-port SRAM after reset,
// then serves reads with one-cycle latency while writes are posted through a
// FIFO write buffer that drains into the SRAM whenever the read port is idle.
//
// Handshake: a request is taken on a rising edge where its strobe (rd / wr)
// is high and the matching wait_req is low; with wait_req high the master
// holds the request unchanged and retries. A taken read returns rd_data in
// the following cycle.
module qrisc32_dmem_slave
  import risc_pack::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   rd_address,
  input  logic          rd,
  output logic          rd_wait_req,
  output logic [31:0]   rd_data,
  input  logic [31:0]   wr_address,
  input  logic [31:0]   wr_data,
  input  logic          wr,
  output logic          wr_wait_req,
  output logic [AW-1:0] sram_addr,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  dmem_state_e   state;
  logic [AW-1:0] init_cnt;
  logic          rd_valid_q;
  logic          fwd_hit_q;
  logic [31:0]   fwd_data_q;

  logic          run;
  logic          rd_serve;
  logic          wb_push;
  logic          wb_pop;
  logic          wb_full;
  logic          wb_empty;
  logic          wb_hit;
  logic [31:0]   wb_hit_data;
  logic [AW-1:0] wb_head_addr;
  logic [31:0]   wb_head_data;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] wr_a;
  logic          unused_addr_bits;

  // Only the low AW address bits select a word.
  assign rd_a             = rd_address[AW-1:0];
  assign wr_a             = wr_address[AW-1:0];
  assign unused_addr_bits = ^{rd_address[31:AW], wr_address[31:AW]};

  assign run = (state == ST_RUN) & ~reset;

  // A read is served unless the buffer is full; then the SRAM slot goes to a
  // drain so the held read can be served next cycle.
  assign rd_serve    = run & rd & ~wb_full;
  assign wb_pop      = run & ~wb_empty & (~rd | wb_full);
  assign rd_wait_req = ~run | wb_full;
  // A full buffer frees a slot for a same-cycle write only through an idle-port
  // drain; the drain forced by a stalled read is reserved for that read.
  assign wr_wait_req = ~run | (wb_full & rd);
  assign wb_push     = run & wr & ~wr_wait_req;

  // Read data: zero when no read was served last cycle, buffered data on a
  // forward hit, otherwise the SRAM output.
  assign rd_data = ~rd_valid_q ? '0 : (fwd_hit_q ? fwd_data_q : sram_rdata);

  qrisc32_wbuf #(
    .AW    (AW),
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .push        (wb_push),
    .push_addr   (wr_a),
    .push_data   (wr_data),
    .pop         (wb_pop),
    .head_addr   (wb_head_addr),
    .head_data   (wb_head_data),
    .full        (wb_full),
    .empty       (wb_empty),
    .lookup_addr (rd_a),
    .hit         (wb_hit),
    .hit_data    (wb_hit_data)
  );

  // SRAM port steering: init fill, then read priority, then buffer drain.
  always_comb begin
    sram_addr  = '0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_wdata = '0;
    if (!reset) begin
      if (state == ST_INIT) begin
        sram_addr = init_cnt;
        sram_ce   = 1'b1;
        sram_we   = 1'b1;
      end else if (rd_serve) begin
        sram_addr = rd_a;
        sram_ce   = 1'b1;
      end else if (wb_pop) begin
        sram_addr  = wb_head_addr;
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_wdata = wb_head_data;
      end
    end
  end

  // Controller FSM plus the read-response registers; the forward lookup sees
  // the buffer before this cycle's push, so a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      rd_valid_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rd_valid_q <= rd_serve;
      fwd_hit_q  <= rd_serve & wb_hit;
      if (rd_serve) begin
        fwd_data_q <= wb_hit_data;
      end
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == {AW{1'b1}}) begin
            state <= ST_RUN;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_qrisc32_dmem_slave.sv
// Bench for qrisc32_dmem_slave with a 16-word SRAM and a 4-entry buffer.
// Reference: an architectural memory image (every accepted write is visible
// to later reads at once), an occupancy number for the buffer and a queue of
// accepted writes that must reach the SRAM in order.
module tb_qrisc32_dmem_slave;

  localparam int AW       = 4;
  localparam int WB_DEPTH = 4;
  localparam int NW       = 1 << AW;
  localparam int W        = AW + 32;

  logic          clk;
  logic          reset;
  logic [31:0]   rd_address;
  logic          rd;
  logic          rd_wait_req;
  logic [31:0]   rd_data;
  logic [31:0]   wr_address;
  logic [31:0]   wr_data;
  logic          wr;
  logic          wr_wait_req;
  logic [AW-1:0] sram_addr;
  logic          sram_ce;
  logic          sram_we;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  qrisc32_dmem_slave #(
    .AW       (AW),
    .WB_DEPTH (WB_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_address  (rd_address),
    .rd          (rd),
    .rd_wait_req (rd_wait_req),
    .rd_data     (rd_data),
    .wr_address  (wr_address),
    .wr_data     (wr_data),
    .wr          (wr),
    .wr_wait_req (wr_wait_req),
    .sram_addr   (sram_addr),
    .sram_ce     (sram_ce),
    .sram_we     (sram_we),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [31:0] sram_mem [NW];

  initial begin
    for (int i = 0; i < NW; i++) sram_mem[i] = $urandom;
    sram_rdata = '0;
  end

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0]  ref_mem [NW];
  logic [W-1:0] exp_q[$];
  int           occ;
  bit           pending;
  logic [31:0]  pending_exp;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("reset_rd_wait_req", rd_wait_req, 1'b1);
      check("reset_wr_wait_req", wr_wait_req, 1'b1);
      check("reset_sram_ce", sram_ce, 1'b0);
      check("reset_sram_we", sram_we, 1'b0);
      check("reset_rd_data", rd_data, 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    exp_q.delete();
    occ     = 0;
    pending = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
  endtask

  // Zero-fill phase; random requests are thrown at it and must be ignored.
  task automatic init_phase();
    for (int i = 0; i < NW; i++) begin
      rd         = 1'($urandom_range(0, 1));
      rd_address = $urandom;
      wr         = 1'($urandom_range(0, 1));
      wr_address = $urandom;
      wr_data    = $urandom;
      @(negedge clk);
      check("init_sram_ce", sram_ce, 1'b1);
      check("init_sram_we", sram_we, 1'b1);
      check("init_sram_addr", sram_addr, i);
      check("init_sram_wdata", sram_wdata, 32'h0);
      check("init_rd_wait_req", rd_wait_req, 1'b1);
      check("init_wr_wait_req", wr_wait_req, 1'b1);
      @(posedge clk); #1;
    end
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // One RUN cycle: checks last cycle's read data, drives the requests,
  // checks the handshake and SRAM port against the model, advances the model.
  task automatic cycle(input logic r, input logic [31:0] ra,
                       input logic w, input logic [31:0] wa, input logic [31:0] wd);
    bit           full;
    bit           exp_drain;
    logic [W-1:0] head;
    if (pending) begin
      check("rd_data", rd_data, pending_exp);
      pending = 1'b0;
    end
    rd         = r;
    rd_address = ra;
    wr         = w;
    wr_address = wa;
    wr_data    = wd;
    @(negedge clk);
    full      = (occ == WB_DEPTH);
    exp_drain = (occ > 0) && (!r || full);
    check("rd_wait_req", rd_wait_req, full);
    check("wr_wait_req", wr_wait_req, full && r);
    if (r && !full) begin
      check("rd_sram_ce", sram_ce, 1'b1);
      check("rd_sram_we", sram_we, 1'b0);
      check("rd_sram_addr", sram_addr, ra[AW-1:0]);
      pending     = 1'b1;
      pending_exp = ref_mem[ra[AW-1:0]];
    end else begin
      check("drain_sram_ce", sram_ce, exp_drain);
      check("drain_sram_we", sram_we, exp_drain);
      if (exp_drain) begin
        head = exp_q.pop_front();
        check("drain_sram_addr", sram_addr, head[W-1:32]);
        check("drain_sram_wdata", sram_wdata, head[31:0]);
        occ--;
      end
    end
    if (w && !(full && r)) begin
      exp_q.push_back({wa[AW-1:0], wd});
      occ++;
      ref_mem[wa[AW-1:0]] = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset      = 1'b1;
    rd         = 1'b0;
    wr         = 1'b0;
    rd_address = '0;
    wr_address = '0;
    wr_data    = '0;
    occ        = 0;
    pending    = 1'b0;
    pending_exp = '0;

    do_reset(3);
    init_phase();

    // Zero-filled memory reads back as zero.
    cycle(1'b1, 32'h3, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'hF, 1'b0, 32'h0, 32'h0);

    // Posted write forwarded to an immediate read before it drains.
    cycle(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF);
    cycle(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    idle(2);

    // Two writes to one word: youngest forwarded, both drain in order.
    cycle(1'b0, 32'h0, 1'b1, 32'h5, 32'h1);
    cycle(1'b0, 32'h0, 1'b1, 32'h5, 32'h2);
    cycle(1'b1, 32'h5, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Same-cycle write and read of one word: read sees the old value.
    cycle(1'b1, 32'h7, 1'b1, 32'h7, 32'hAA);
    cycle(1'b1, 32'h7, 1'b0, 32'h0, 32'h0);
    idle(3);

    // Fill the buffer under continuous reads, then stall both ports.
    for (int i = 0; i < WB_DEPTH; i++)
      cycle(1'b1, 32'($urandom_range(0, NW - 1)), 1'b1, 32'(i + 8), $urandom);
    cycle(1'b1, 32'h2, 1'b1, 32'h2, 32'h1234_5678);
    cycle(1'b1, 32'h2, 1'b0, 32'h0, 32'h0);
    idle(6);

    // Random traffic with upper address bits scrambled.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), $urandom,
            1'($urandom_range(0, 1)), $urandom, $urandom);
    idle(8);

    // Reset with writes still buffered: they must be dropped.
    cycle(1'b1, 32'h0, 1'b1, 32'h3, 32'h111);
    cycle(1'b1, 32'h0, 1'b1, 32'h9, 32'h222);
    cycle(1'b1, 32'h0, 1'b1, 32'hC, 32'h333);
    do_reset(2);
    init_phase();
    idle(2);
    cycle(1'b1, 32'h3, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'h9, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
